phi0_divider: RTL and testbench



---
 rtl/core6502_clk_pkg.sv | 12 +
 rtl/phi0_phase_cnt.sv | 43 ++++
 rtl/phi0_divider.sv | 119 +++++++++++
 tb/tb_phi0_divider.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/core6502_clk_pkg.sv
// Shared constants and types for the 6502 clock generation blocks.
package core6502_clk_pkg;
  localparam int PHI0_DIV_NTSC = 12;
  localparam int PHI0_DIV_PAL  = 16;
  localparam int CYC_W         = 16;

  typedef logic [CYC_W-1:0] cyc_t;

  function automatic cyc_t cyc_inc(input cyc_t c);
    return c + cyc_t'(1);
  endfunction
endpackage

// File: rtl/phi0_phase_cnt.sv
// Wrapping phase counter (0..DIV-1) with hold; decodes next-phase PHI0 level,
// rise point and wrap for the output registers in phi0_divider.
module phi0_phase_cnt #(
  parameter int DIV = 12,
  parameter int L   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  output logic [$clog2(DIV)-1:0]  cnt_next,
  output logic                    wrap,
  output logic                    rise_dec,
  output logic                    high_dec
);
  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    wrap     = 1'b0;
    if (hold) begin
      cnt_d = cnt_q;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_d = '0;
      wrap  = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    cnt_next = cnt_d;
    rise_dec = (cnt_d == CW'(L));
    high_dec = (cnt_d >= CW'(L));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/phi0_divider.sv
// PHI0 master-clock divider with edge strobes and completed-cycle counter.
// Optional stall handshake is built only when PHI0_STALL_EN is defined.
module phi0_divider
  import core6502_clk_pkg::*;
#(
  parameter int DIV  = PHI0_DIV_NTSC,
  parameter int HIGH = 6
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             STALL,
  output logic             PHI0,
  output logic             PHI0_RISE,
  output logic             PHI0_FALL,
  output logic             STALL_ACK,
  output logic [CYC_W-1:0] CYC
);
  localparam int L  = DIV - HIGH;
  localparam int CW = $clog2(DIV);

  generate
    if (DIV < 2 || HIGH < 1 || HIGH > DIV - 1) begin : g_bad_cfg
      $error("phi0_divider: illegal DIV/HIGH combination");
    end
  endgenerate

  logic          hold_s;
  logic [CW-1:0] cnt_next_s;
  logic          wrap_s;
  logic          rise_dec_s;
  logic          high_dec_s;

  phi0_phase_cnt #(.DIV(DIV), .L(L)) u_cnt (
    .clk      (CLK),
    .rst      (RES),
    .hold     (hold_s),
    .cnt_next (cnt_next_s),
    .wrap     (wrap_s),
    .rise_dec (rise_dec_s),
    .high_dec (high_dec_s)
  );

  // Only the decoded flags are consumed here; the raw phase is kept for observation.
  logic [CW-1:0] unused_cnt_s;
  assign unused_cnt_s = cnt_next_s;

  logic phi0_q, phi0_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic ack_q,  ack_d;
  cyc_t cyc_q,  cyc_d;

`ifdef PHI0_STALL_EN
  logic frozen_q, frozen_d;

  // STALL only matters at the wrap edge or while already frozen.
  always_comb begin
    frozen_d = frozen_q;
    if (frozen_q) begin
      frozen_d = STALL;
    end else begin
      frozen_d = wrap_s & STALL;
    end
    hold_s = frozen_q & STALL;
    ack_d  = frozen_d;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      frozen_q <= 1'b0;
    end else begin
      frozen_q <= frozen_d;
    end
  end
`else
  logic unused_stall_s;
  assign unused_stall_s = STALL;

  always_comb begin
    hold_s = 1'b0;
    ack_d  = 1'b0;
  end
`endif

  // Frozen phase holds cnt at 0, so the decodes alone keep PHI0 low and strobes quiet.
  always_comb begin
    phi0_d = high_dec_s;
    rise_d = rise_dec_s;
    fall_d = wrap_s;
    cyc_d  = cyc_q;
    if (wrap_s) begin
      cyc_d = cyc_inc(cyc_q);
    end else begin
      cyc_d = cyc_q;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      phi0_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      ack_q  <= 1'b0;
      cyc_q  <= '0;
    end else begin
      phi0_q <= phi0_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      ack_q  <= ack_d;
      cyc_q  <= cyc_d;
    end
  end

  assign PHI0      = phi0_q;
  assign PHI0_RISE = rise_q;
  assign PHI0_FALL = fall_q;
  assign STALL_ACK = ack_q;
  assign CYC       = cyc_q;
endmodule

// File: tb/tb_phi0_divider.sv
// Bench for phi0_divider: NTSC (12/6) and L=15 (16/1) instances share stimulus.
module tb_phi0_divider;
`ifdef PHI0_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic CLK, RES, STALL;
  logic p12, r12, f12, a12;
  logic [15:0] c12;
  logic p16, r16, f16, a16;
  logic [15:0] c16;

  phi0_divider #(.DIV(12), .HIGH(6)) dut12 (
    .CLK(CLK), .RES(RES), .STALL(STALL), .PHI0(p12), .PHI0_RISE(r12),
    .PHI0_FALL(f12), .STALL_ACK(a12), .CYC(c12)
  );
  phi0_divider #(.DIV(16), .HIGH(1)) dut16 (
    .CLK(CLK), .RES(RES), .STALL(STALL), .PHI0(p16), .PHI0_RISE(r16),
    .PHI0_FALL(f16), .STALL_ACK(a16), .CYC(c16)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int   pos;
    bit   frozen;
    bit   phi0, rise, fall, ack;
    logic [15:0] cyc;
  } mstate_t;

  typedef struct packed {
    logic phi0, rise, fall, ack;
    logic [15:0] cyc;
  } obs_t;

  typedef struct {
    int edge_n;
    bit p12, r12, f12;
    int c12;
    bit p16, r16, f16;
  } vec_t;

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  mstate_t m12, m16;
  obs_t q12[$];
  obs_t q16[$];
  vec_t tbl[12];

  function automatic mstate_t mstep(input mstate_t s, input int div, input int l,
                                    input bit stall, input bit res);
    mstate_t n;
    n = s;
    if (res) begin
      n.pos = 0; n.frozen = 0; n.phi0 = 0; n.rise = 0; n.fall = 0; n.ack = 0;
      n.cyc = 16'h0000;
      return n;
    end
    if (s.frozen) begin
      if (!stall) begin
        n.frozen = 0;
        n.pos = 1;
      end
    end else if (s.pos == div - 1) begin
      n.pos = 0;
      n.cyc = s.cyc + 16'd1;
      if (STALL_ON && stall) n.frozen = 1;
    end else begin
      n.pos = s.pos + 1;
    end
    n.phi0 = (n.pos >= l);
    n.rise = n.phi0 && !s.phi0;
    n.fall = !n.phi0 && s.phi0;
    n.ack  = n.frozen;
    return n;
  endfunction

  function automatic obs_t to_obs(input mstate_t s);
    obs_t o;
    o.phi0 = s.phi0; o.rise = s.rise; o.fall = s.fall; o.ack = s.ack; o.cyc = s.cyc;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h edge=%0d t=%0t", nm, got, exp, edge_n, $time);
    end
  endtask

  task automatic tick();
    obs_t e12, e16;
    @(posedge CLK);
    m12 = mstep(m12, 12, 6, STALL, RES);
    m16 = mstep(m16, 16, 15, STALL, RES);
    q12.push_back(to_obs(m12));
    q16.push_back(to_obs(m16));
    edge_n++;
    @(negedge CLK);
    e12 = q12.pop_front();
    e16 = q16.pop_front();
    chk("sb12", {12'h0, p12, r12, f12, a12, c12}, {12'h0, e12});
    chk("sb16", {12'h0, p16, r16, f16, a16, c16}, {12'h0, e16});
  endtask

  task automatic run_table();
    for (int i = 0; i < 12; i++) begin
      while (edge_n < tbl[i].edge_n) tick();
      chk("tbl_phi0_12", 32'(p12), 32'(tbl[i].p12));
      chk("tbl_rise_12", 32'(r12), 32'(tbl[i].r12));
      chk("tbl_fall_12", 32'(f12), 32'(tbl[i].f12));
      chk("tbl_cyc_12",  32'(c12), 32'(tbl[i].c12));
      chk("tbl_phi0_16", 32'(p16), 32'(tbl[i].p16));
      chk("tbl_rise_16", 32'(r16), 32'(tbl[i].r16));
      chk("tbl_fall_16", 32'(f16), 32'(tbl[i].f16));
    end
  endtask

  task automatic async_reset_check(input string nm);
    #2 RES = 1'b1;
    #1;
    chk({nm, "_phi0"}, 32'(p12), 32'd0);
    chk({nm, "_rise"}, 32'(r12), 32'd0);
    chk({nm, "_fall"}, 32'(f12), 32'd0);
    chk({nm, "_ack"},  32'(a12), 32'd0);
    chk({nm, "_cyc"},  32'(c12), 32'd0);
    chk({nm, "_cyc16"}, 32'(c16), 32'd0);
    m12 = mstep(m12, 12, 6, 1'b0, 1'b1);
    m16 = mstep(m16, 16, 15, 1'b0, 1'b1);
  endtask

  initial begin
    int ack_cnt;
    int rise_a;
    int rise_b;
    int found;

    tbl[0]  = '{5,  0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{6,  1, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{7,  1, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{12, 0, 0, 1, 1, 0, 0, 0};
    tbl[4]  = '{15, 0, 0, 0, 1, 1, 1, 0};
    tbl[5]  = '{16, 0, 0, 0, 1, 0, 0, 1};
    tbl[6]  = '{18, 1, 1, 0, 1, 0, 0, 0};
    tbl[7]  = '{24, 0, 0, 1, 2, 0, 0, 0};
    tbl[8]  = '{30, 1, 1, 0, 2, 0, 0, 0};
    tbl[9]  = '{31, 1, 0, 0, 2, 1, 1, 0};
    tbl[10] = '{32, 1, 0, 0, 2, 0, 0, 1};
    tbl[11] = '{36, 0, 0, 1, 3, 0, 0, 0};

    RES = 1'b1;
    STALL = 1'b0;
    m12 = mstep(m12, 12, 6, 1'b0, 1'b1);
    m16 = mstep(m16, 16, 15, 1'b0, 1'b1);
    #2;
    chk("rst_outs12", {p12, r12, f12, a12, c12}, 20'h0);
    chk("rst_outs16", {p16, r16, f16, a16, c16}, 20'h0);
    tick();
    tick();
    RES = 1'b0;
    edge_n = 0;
    run_table();

    // Stall held across the wrap at edge 48, released so edge 54 samples it low.
    while (edge_n < 45) tick();
    STALL = 1'b1;
    ack_cnt = 0;
    rise_a = -1;
    while (edge_n < 59) begin
      tick();
      if (a12) ack_cnt++;
      if (r12 && rise_a < 0 && edge_n > 53) rise_a = edge_n;
      if (edge_n == 53) STALL = 1'b0;
    end
    chk("stall_ack_len", 32'(ack_cnt), STALL_ON ? 32'd6 : 32'd0);
    chk("stall_rise_edge", 32'(rise_a), STALL_ON ? 32'd59 : 32'd54);

    // Short pulse away from any wrap edge.
    STALL = 1'b1;
    ack_cnt = 0;
    rise_a = -1;
    rise_b = -1;
    while (edge_n < 90) begin
      tick();
      if (edge_n == 62) STALL = 1'b0;
      if (a12 || a16) ack_cnt++;
      if (r12 && edge_n > 59) begin
        if (rise_a < 0) rise_a = edge_n;
        else if (rise_b < 0) rise_b = edge_n;
      end
    end
    chk("pulse_ack", 32'(ack_cnt), 32'd0);
    chk("pulse_period", 32'(rise_b - rise_a), 32'd12);

    // Asynchronous reset in the high phase.
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      tick();
      if (p12 && !r12) found = 1;
    end
    chk("find_high", 32'(found), 32'd1);
    async_reset_check("ares_high");
    tick();
    RES = 1'b0;
    edge_n = 0;
    run_table();

    // Asynchronous reset while frozen (edge 50 sits inside the stall window).
    STALL = 1'b1;
    while (edge_n < 50) tick();
    chk("pre_ares_ack", 32'(a12), 32'(STALL_ON));
    async_reset_check("ares_stall");
    STALL = 1'b0;
    tick();
    RES = 1'b0;
    edge_n = 0;

    // CYC preload near wrap.
    while (edge_n < 13) tick();
    force dut12.cyc_q = 16'hFFFE;
    m12.cyc = 16'hFFFE;
    #1 release dut12.cyc_q;
    while (edge_n < 24) tick();
    chk("cyc_ffff", 32'(c12), 32'h0000FFFF);
    while (edge_n < 36) tick();
    chk("cyc_wrap0", 32'(c12), 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
